// File: rtl/counter_round.sv
// Round/step counter for a memory-style game: round n needs n accepted user steps,
// a one-cycle tc marks each completed round, and the game ends in WIN after MAX_ROUND.
module counter_round #(
  parameter int WIDTH     = 4,
  parameter int MAX_ROUND = 15,
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic             E,
  input  logic             fail,
  output logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] round,
  output logic             tc,
  output logic             win,
  output logic             lost,
  output logic             busy
);

  if (MAX_ROUND < 1 || MAX_ROUND > (2 ** WIDTH) - 1) begin : g_bad_max_round
    $error("counter_round: MAX_ROUND must lie in 1 .. 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_R = WIDTH'(MAX_ROUND);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    WIN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] round_q, round_d;
  logic             e_d_q, e_d_d;
  logic             tc_q, tc_d;
  logic             win_q, win_d;
  logic             lost_q, lost_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic [WIDTH-1:0] step_inc;

  // Edge mode counts only a fresh rise of E, so a level held into WAIT never counts.
  assign accept   = (EDGE_MODE != 0) ? (E & ~e_d_q) : E;
  assign step_inc = step_q + ONE;

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      step_q  <= '0;
      round_q <= '0;
      e_d_q   <= 1'b0;
      tc_q    <= 1'b0;
      win_q   <= 1'b0;
      lost_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
      e_d_q   <= e_d_d;
      tc_q    <= tc_d;
      win_q   <= win_d;
      lost_q  <= lost_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    lost_d  = lost_q;
    e_d_d   = E;
    unique case (state_q)
      IDLE, WIN: begin
        if (start) begin
          round_d = ONE;
          step_d  = '0;
          lost_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A wrong entry wins over a step arriving in the same cycle.
        if (fail) begin
          lost_d  = 1'b1;
          step_d  = '0;
          state_d = IDLE;
        end else if (accept) begin
          if (step_inc == round_q) begin
            step_d  = round_q;
            state_d = DONE;
          end else begin
            step_d = step_inc;
          end
        end
      end
      DONE: begin
        if (round_q == MAX_R) begin
          state_d = WIN;
        end else begin
          round_d = round_q + ONE;
          step_d  = '0;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies decoded from the next state.
    tc_d   = (state_d == DONE);
    win_d  = (state_d == WIN);
    busy_d = (state_d == WAIT) || (state_d == DONE);
  end

  assign step  = step_q;
  assign round = round_q;
  assign tc    = tc_q;
  assign win   = win_q;
  assign lost  = lost_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_counter_round.sv
// Directed bench for counter_round: edge-mode instance (MAX_ROUND=3) plus a level-mode instance.
module tb_counter_round;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       start = 1'b0, E = 1'b0, fail = 1'b0;
  logic       start_b = 1'b0, E_b = 1'b0, fail_b = 1'b0;
  logic [3:0] step, round, step_b, round_b;
  logic       tc, win, lost, busy, tc_b, win_b, lost_b, busy_b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  counter_round #(.WIDTH(4), .MAX_ROUND(3), .EDGE_MODE(1)) dut (
    .clk(clk), .R(R), .start(start), .E(E), .fail(fail),
    .step(step), .round(round), .tc(tc), .win(win), .lost(lost), .busy(busy)
  );

  counter_round #(.WIDTH(4), .MAX_ROUND(3), .EDGE_MODE(0)) dut_b (
    .clk(clk), .R(R), .start(start_b), .E(E_b), .fail(fail_b),
    .step(step_b), .round(round_b), .tc(tc_b), .win(win_b), .lost(lost_b), .busy(busy_b)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({step, round, tc, win, lost, busy} !== 12'h000) begin
      failures++; $display("FAIL reset_outputs got=%h exp=000", {step, round, tc, win, lost, busy});
    end
    R = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || round !== 4'd0) begin
      failures++; $display("FAIL reset_release_idle got busy=%b round=%0d exp busy=0 round=0", busy, round);
    end
  endtask

  task automatic test_one_step();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (round !== 4'd1 || step !== 4'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_state got round=%0d step=%0d busy=%b exp 1 0 1", round, step, busy);
    end
    E = 1'b1; tick();
    checks++;
    if (tc !== 1'b1 || step !== 4'd1) begin
      failures++; $display("FAIL one_step_tc got tc=%b step=%0d exp tc=1 step=1", tc, step);
    end
    E = 1'b0; tick();
    checks++;
    if (tc !== 1'b0 || round !== 4'd2 || step !== 4'd0) begin
      failures++; $display("FAIL one_step_next got tc=%b round=%0d step=%0d exp 0 2 0", tc, round, step);
    end
  endtask

  task automatic test_full_game();
    int tcs;
    tcs = 0;
    start = 1'b1; tick(); start = 1'b0;   // from WAIT: must be ignored
    checks++;
    if (round !== 4'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL start_ignored_wait got round=%0d busy=%b exp round=2 busy=1", round, busy);
    end
    R = 1'b0; tick(); R = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      for (int k = 0; k < r; k++) begin
        E = 1'b1; tick(); if (tc === 1'b1) tcs++;
        E = 1'b0; tick(); if (tc === 1'b1) tcs++;
      end
    end
    checks++;
    if (tcs != 3) begin
      failures++; $display("FAIL full_game_tc_count got=%0d exp=3", tcs);
    end
    checks++;
    if (win !== 1'b1 || round !== 4'd3 || step !== 4'd3 || busy !== 1'b0) begin
      failures++; $display("FAIL full_game_win got win=%b round=%0d step=%0d busy=%b exp 1 3 3 0", win, round, step, busy);
    end
    E = 1'b1; tick(); E = 1'b0; tick();
    checks++;
    if (win !== 1'b1 || tc !== 1'b0 || step !== 4'd3) begin
      failures++; $display("FAIL win_hold got win=%b tc=%b step=%0d exp 1 0 3", win, tc, step);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (win !== 1'b0 || round !== 4'd1 || step !== 4'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL restart_from_win got win=%b round=%0d step=%0d busy=%b exp 0 1 0 1", win, round, step, busy);
    end
  endtask

  task automatic test_fail_priority();
    E = 1'b1; tick(); E = 1'b0; tick();   // finish round 1
    E = 1'b1; tick(); E = 1'b0; tick();   // round 2, step 1
    checks++;
    if (round !== 4'd2 || step !== 4'd1) begin
      failures++; $display("FAIL fail_setup got round=%0d step=%0d exp 2 1", round, step);
    end
    fail = 1'b1; E = 1'b1; tick();
    checks++;
    if (lost !== 1'b1 || step !== 4'd0 || round !== 4'd2 || busy !== 1'b0 || tc !== 1'b0) begin
      failures++; $display("FAIL fail_priority got lost=%b step=%0d round=%0d busy=%b tc=%b exp 1 0 2 0 0",
                           lost, step, round, busy, tc);
    end
    E = 1'b0; tick(); tick();
    fail = 1'b0;
    checks++;
    if (lost !== 1'b1 || busy !== 1'b0 || round !== 4'd2) begin
      failures++; $display("FAIL lost_held got lost=%b busy=%b round=%0d exp 1 0 2", lost, busy, round);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (lost !== 1'b0 || round !== 4'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL restart_after_lost got lost=%b round=%0d busy=%b exp 0 1 1", lost, round, busy);
    end
  endtask

  task automatic test_e_held();
    E = 1'b1; tick(); E = 1'b0; tick();   // finish round 1
    E = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (step !== 4'd1 || round !== 4'd2) begin
      failures++; $display("FAIL e_held_single got step=%0d round=%0d exp 1 2", step, round);
    end
    E = 1'b0; tick();
    E = 1'b1; tick();
    checks++;
    if (tc !== 1'b1 || step !== 4'd2) begin
      failures++; $display("FAIL e_held_done got tc=%b step=%0d exp 1 2", tc, step);
    end
    tick(); tick(); tick();
    checks++;
    if (step !== 4'd0 || round !== 4'd3 || tc !== 1'b0) begin
      failures++; $display("FAIL e_across_done got step=%0d round=%0d tc=%b exp 0 3 0", step, round, tc);
    end
    E = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    E = 1'b1; tick(); E = 1'b0;
    checks++;
    if (step !== 4'd1 || round !== 4'd3) begin
      failures++; $display("FAIL mid_setup got step=%0d round=%0d exp 1 3", step, round);
    end
    #1 R = 1'b0;
    #1;
    checks++;
    if ({step, round, tc, win, lost, busy} !== 12'h000) begin
      failures++; $display("FAIL async_reset got=%h exp=000", {step, round, tc, win, lost, busy});
    end
    tick();
    R = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || round !== 4'd0 || tc !== 1'b0) begin
      failures++; $display("FAIL reset_wait_start got busy=%b round=%0d tc=%b exp 0 0 0", busy, round, tc);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (round !== 4'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL start_after_reset got round=%0d busy=%b exp 1 1", round, busy);
    end
  endtask

  task automatic test_level_mode();
    start_b = 1'b1; tick(); start_b = 1'b0;
    E_b = 1'b1; tick(); E_b = 1'b0; tick();   // round 1 done
    E_b = 1'b1; tick(); tick(); E_b = 1'b0; tick();   // round 2 done
    checks++;
    if (round_b !== 4'd3 || step_b !== 4'd0) begin
      failures++; $display("FAIL level_setup got round=%0d step=%0d exp 3 0", round_b, step_b);
    end
    E_b = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      tick();
      checks++;
      if (step_b !== 4'(s) || tc_b !== (s == 3)) begin
        failures++; $display("FAIL level_step%0d got step=%0d tc=%b exp step=%0d tc=%b", s, step_b, tc_b, s, (s == 3));
      end
    end
    E_b = 1'b0; tick();
    checks++;
    if (win_b !== 1'b1 || tc_b !== 1'b0 || busy_b !== 1'b0) begin
      failures++; $display("FAIL level_win got win=%b tc=%b busy=%b exp 1 0 0", win_b, tc_b, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_one_step();
    test_full_game();
    test_fail_priority();
    test_e_held();
    test_reset_mid();
    test_level_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_round.md
COUNTER_ROUND -- requirements
Module: counter_round

Interface
REQ-001 Parameter WIDTH, default 4: width of the step and round counters.
REQ-002 Parameter MAX_ROUND, default 15: final round of a game; SHALL satisfy 1 <= MAX_ROUND <= 2^WIDTH-1, checked at elaboration.
REQ-003 Parameter EDGE_MODE, default 1: 1 = one step per E rising edge; 0 = one step per clock cycle with E high.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 R  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a new game; sampled only in IDLE or WIN.
REQ-007 E  input  1  user-step strobe from button logic.
REQ-008 fail  input  1  wrong user entry for the current round.
REQ-009 step  output  WIDTH  user steps accepted in the current round.
REQ-010 round  output  WIDTH  current round number; round n needs n steps.
REQ-011 tc  output  1  one-cycle pulse on round completion.
REQ-012 win  output  1  level, high in WIN.
REQ-013 lost  output  1  level, high after fail until the next start.
REQ-014 busy  output  1  high in WAIT and DONE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, DONE and WIN; all outputs SHALL be registered.
REQ-016 IDLE, start=1: round<=1, step<=0, lost<=0, next state WAIT.
REQ-017 WAIT, accepted step (REQ-021) and step+1 < round: step<=step+1, stay in WAIT.
REQ-018 WAIT, accepted step and step+1 == round: step<=round, next state DONE.
REQ-019 DONE lasts exactly one cycle with tc=1: if round == MAX_ROUND, go to WIN with step and round held; else round<=round+1, step<=0, go to WAIT.
REQ-020 WIN: win=1 and busy=0; start=1 restarts as in REQ-016 (round<=1, step<=0, win<=0).
REQ-021 Step acceptance, EDGE_MODE=1: E==1 and registered E_d==0; E_d SHALL update every cycle in every state.
REQ-022 Step acceptance, EDGE_MODE=0: E==1 in the cycle.
REQ-023 Step-to-tc latency: tc SHALL be high in the cycle after the clock edge that accepts the final step of a round.
REQ-024 WAIT, fail=1: lost<=1, step<=0, round held, next state IDLE; fail SHALL take priority over a step in the same cycle.
REQ-025 fail SHALL be ignored in IDLE, DONE and WIN.
REQ-026 start SHALL be ignored in WAIT and DONE.
REQ-027 E SHALL be ignored outside WAIT; in EDGE_MODE=1 an E held high across entry into WAIT SHALL NOT count until it falls and rises again.
REQ-028 step and round SHALL never exceed MAX_ROUND and SHALL never wrap; counter arithmetic is WIDTH bits, with comparisons at full width.
REQ-029 tc SHALL be 0 in every state except DONE.

Reset
REQ-030 R=0 SHALL force, asynchronously: state=IDLE, step=0, round=0, E_d=0, tc=0, win=0, lost=0, busy=0.
REQ-031 Assertion of R mid-game (WAIT or DONE) SHALL abandon the game with no tc pulse; after release, the block SHALL wait for start.
REQ-032 Release of R SHALL be synchronous to clk; the first state change after release SHALL require start=1.

Verification (WIDTH=4, MAX_ROUND=3, EDGE_MODE=1)
REQ-033 Start, then 1 E pulse -> tc high one cycle after the accepting edge; round=2, step=0.
REQ-034 Full game of 1+2+3 E pulses -> exactly three tc pulses, then win=1, round=3, step=3, busy=0.
REQ-035 Round 2, after 1 step, fail and E high in the same cycle -> lost=1, step=0, round=2, state IDLE, no tc.
REQ-036 E held high for 10 cycles in WAIT -> step increments by exactly 1; E held high across the DONE->WAIT transition -> no extra step.
REQ-037 R=0 in the middle of round 3 -> all outputs 0 immediately (before the next clk edge); start after release -> round=1.
REQ-038 EDGE_MODE=0, round 3, E high for 3 cycles -> step 1,2,3 on consecutive edges, then tc, then win=1.
